// File: rtl/serial_mod_n.sv
`default_nettype none
// ============================================================================
//  Module      : serial_mod_n
//  Description : Bit-serial divisibility checker. Accumulates a number that
//                arrives one bit per accepted cycle, in MSB-first or LSB-first
//                order, and keeps its running residue modulo MOD.
//  Ports       :
//    clk        in   single clock, all state changes on posedge
//    rst        in   asynchronous reset, active low
//    x          in   serial data bit
//    valid      in   x is a live bit this cycle
//    clr        in   synchronous start of a new number
//    msb_first  in   bit order for the next number, sampled only with clr=1
//    z          out  registered, 1 when the number so far is divisible by MOD
//    residue    out  registered, number so far mod MOD
//    bit_cnt    out  registered, saturating count of accepted bits
//    cnt_sat    out  registered, 1 when bit_cnt is at its maximum
//    order      out  registered, active bit order (1 = MSB-first)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_mod_n #(
   parameter int MOD     = 3,
   parameter int RW      = 8,
   parameter int CNT_W   = 8,
   parameter bit DEF_MSB = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             valid,
   input  logic             clr,
   input  logic             msb_first,
   output logic             z,
   output logic [RW-1:0]    residue,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             cnt_sat,
   output logic             order
);

   // Parameter legality is checked at elaboration time.
   generate
      if ((MOD < 2) || (MOD > 255)) begin : g_bad_mod
         $error("serial_mod_n: MOD must be in 2..255");
      end
      if ((RW < 1) || (RW > 30) || ((1 << RW) < MOD)) begin : g_bad_rw
         $error("serial_mod_n: RW too small for MOD");
      end
      if (CNT_W < 1) begin : g_bad_cnt
         $error("serial_mod_n: CNT_W must be at least 1");
      end
   endgenerate

   localparam logic [RW:0]      MOD_X   = (RW+1)'(MOD);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Operands are always below 2*MOD, so one conditional subtract reduces them.
   function automatic logic [RW-1:0] reduce(input logic [RW:0] v);
      logic [RW:0] t;
      t = (v >= MOD_X) ? (v - MOD_X) : v;
      return t[RW-1:0];
   endfunction

   logic [RW-1:0]    r_q,       r_d;
   logic [RW-1:0]    w_q,       w_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             order_q,   order_d;
   logic             z_q,       z_d;
   logic             cnt_sat_q, cnt_sat_d;

   // Starting point for this cycle's update: a clr restarts the number, and a
   // bit arriving with clr is treated as the first bit of the fresh number.
   logic [RW-1:0]    base_r;
   logic [RW-1:0]    base_w;
   logic [CNT_W-1:0] base_cnt;
   logic             order_eff;
   logic [RW:0]      sum;

   always_comb begin
      base_r    = clr ? '0 : r_q;
      base_w    = clr ? RW'(1) : w_q;
      base_cnt  = clr ? '0 : cnt_q;
      order_eff = clr ? msb_first : order_q;
      sum       = '0;

      r_d     = base_r;
      w_d     = base_w;
      cnt_d   = base_cnt;
      order_d = order_eff;

      if (valid) begin
         if (order_eff) begin
            sum = {base_r, 1'b0} + {{RW{1'b0}}, x};
         end else begin
            sum = {1'b0, base_r} + (x ? {1'b0, base_w} : '0);
         end
         r_d = reduce(sum);

         // The LSB weight advances per bit in LSB-first mode; a first bit
         // taken with clr always leaves the weight at 2 mod MOD.
         if (!order_eff || clr) begin
            w_d = reduce({base_w, 1'b0});
         end

         cnt_d = (base_cnt == CNT_MAX) ? base_cnt : (base_cnt + CNT_W'(1));
      end

      z_d       = (r_d == '0);
      cnt_sat_d = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q       <= '0;
         w_q       <= RW'(1);
         cnt_q     <= '0;
         order_q   <= DEF_MSB;
         z_q       <= 1'b1;
         cnt_sat_q <= 1'b0;
      end else begin
         r_q       <= r_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         order_q   <= order_d;
         z_q       <= z_d;
         cnt_sat_q <= cnt_sat_d;
      end
   end

   assign z       = z_q;
   assign residue = r_q;
   assign bit_cnt = cnt_q;
   assign cnt_sat = cnt_sat_q;
   assign order   = order_q;

endmodule
`default_nettype wire
